load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-stage consumer of the ALU result: takes the computed effective address plus rs2 store data and runs a variable-latency data-memory transaction over a req/ack bus.
- Generates byte enables and store lane replication; extracts, sign-extends or zero-extends load data.
- Stalls the pipeline while a transaction is in flight.
- Flags misaligned accesses and bus timeouts instead of issuing them.

Parameters:
DATA_WIDTH, 32, data and address width in bits (fixed 32 for RV32).
TIMEOUT_CYCLES, 255, maximum REQ cycles without mem_ack before abort; 0 disables the timeout.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
MemRead  input  1  load instruction present
MemWrite  input  1  store instruction present
Funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  input  32  effective byte address from ALU
WriteData  input  32  rs2 store data
Stall  output  1  hold upstream pipeline registers
ReadData  output  32  extended load result
RdValid  output  1  one-cycle pulse: ReadData updated this cycle
MisalignErr  output  1  one-cycle pulse: misaligned or illegal access rejected
TimeoutErr  output  1  one-cycle pulse: transaction aborted by timeout
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  word address, bits [1:0] = 00
mem_wdata  output  32  store data, lanes replicated
mem_be  output  4  byte enables
mem_ack  input  1  transaction complete; read data valid this cycle
mem_rdata  input  32  read word

Behaviour:
- Reset (reset=0 at an edge):
  - FSM to IDLE; timeout counter 0.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0.
  - ReadData = 0; RdValid, MisalignErr, TimeoutErr = 0.
  - Applies mid-transaction: mem_req is low in the cycle after the reset edge; any in-flight ack is dropped.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - request = MemRead | MemWrite; MemWrite wins if both are set.
  - On request: latch address, data, Funct3, we.
  - Legal: B/BU any address; H/HU addr[0]=0; W addr[1:0]=00. Legal -> REQ.
  - Misaligned, or load funct3 in {011,110,111}, or store funct3 not in {000,001,010} -> ERR.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata are held stable from registers until ack.
  - On mem_ack -> DONE; for loads, mem_rdata is captured on that edge.
  - Counter increments each REQ cycle without ack. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES -> ERR with timeout cause; mem_req drops.
- DONE:
  - One cycle, then IDLE; a request visible on the inputs in this cycle is not accepted.
  - Load: ReadData updated, RdValid=1.
  - Store: no RdValid.
- ERR: one cycle, then IDLE. MisalignErr=1 or TimeoutErr=1 per cause; no bus activity for misaligned accesses.
- Stall = (IDLE & request) | REQ, combinational. It is low in DONE and ERR so the pipeline advances exactly once per instruction.
- Latency with zero-wait memory (ack in the first REQ cycle):
  - accept cycle 0, ack cycle 1, DONE cycle 2.
  - Stall high for 2 cycles; each extra wait cycle adds 1.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - W: 1111.
- Store data: B replicates WriteData[7:0] to all 4 lanes; H replicates [15:0] to both halves; W passes through.
- Load extraction: lane selected by latched addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- ReadData holds its value until the next completed load or reset.
- mem_ack outside REQ is ignored.

Test Plan:
- LW addr 0x100, rdata 0x87654321, ack zero-wait -> mem_addr 0x100, be 1111, we 0; Stall high 2 cycles; cycle 2 ReadData 0x87654321, RdValid pulse.
- LB addr 0x103, rdata 0x80FFFF7F -> ReadData 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x100 same rdata -> 0xFFFFFF7F.
- SH addr 0x202, WriteData 0x1234BEEF -> mem_addr 0x200, be 1100, wdata 0xBEEFBEEF, we 1; no RdValid.
- SW addr 0x101 -> no mem_req; ERR next cycle with MisalignErr pulse; Stall high exactly 1 cycle. Same for LH addr 0x001.
- LW with ack after 5 wait cycles -> mem_req/addr stable 6 cycles, ReadData correct. With TIMEOUT_CYCLES=8 and no ack -> TimeoutErr pulse after 8 REQ cycles, mem_req low, return to IDLE.
- reset=0 during REQ -> next cycle IDLE, mem_req 0, ReadData 0; late ack ignored; subsequent LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage load/store engine. Accepts an effective address and rs2 data
// from the ALU stage and runs one data-memory transaction over a req/ack bus.
// It builds byte enables, replicates store data across byte lanes, and
// extracts plus extends load data. Misaligned or illegal accesses and bus
// timeouts are reported as one-cycle error pulses instead of being issued.
//
// Ports
//   clk, reset     clock; synchronous active-low reset
//   MemRead        load present
//   MemWrite       store present (wins over MemRead)
//   Funct3         access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResult      effective byte address
//   WriteData      rs2 store data
//   Stall          hold upstream pipeline registers
//   ReadData       extended load result, held until the next completed load
//   RdValid        pulse: ReadData updated this cycle
//   MisalignErr    pulse: misaligned or illegal access rejected
//   TimeoutErr     pulse: transaction aborted by timeout
//   mem_req/we/addr/wdata/be   bus request side (word address, lanes replicated)
//   mem_ack/rdata  bus completion and read word
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [2:0]              Funct3,
    input  logic [DATA_WIDTH-1:0]   ALUResult,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    output logic                    Stall,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    RdValid,
    output logic                    MisalignErr,
    output logic                    TimeoutErr,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    // Count value at which the final allowed REQ cycle is running.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             tmo_cnt;
    logic [1:0]              lane_q;
    logic [2:0]              f3_q;
    logic                    we_q;
    logic                    tmo_q;

    logic                    request;
    logic                    aligned;
    logic                    f3_ok;
    logic                    tmo_hit;
    logic [NUM_LANES-1:0]    be_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   ld_ext;

    // ---------------- request decode ----------------
    always_comb begin
        request = MemRead | MemWrite;
        unique case (Funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ALUResult[0];
            2'b10:   aligned = (ALUResult[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        // Stores only have signed encodings; loads add BU/HU but not 110/111.
        if (MemWrite)
            f3_ok = ~Funct3[2] & (Funct3[1:0] != 2'b11);
        else
            f3_ok = (Funct3[1:0] != 2'b11) & (Funct3 != 3'b110);
    end

    always_comb begin
        unique case (Funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << ALUResult[1:0];
                wdata_nxt = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_nxt    = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{WriteData[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = WriteData;
            end
        endcase
    end

    // ---------------- load extraction ----------------
    always_comb begin
        rd_shift = mem_rdata >> {lane_q, 3'b000};
        unique case (f3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_ext = {24'b0, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_ext = {16'b0, rd_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        Stall       = 1'b0;
        mem_req     = 1'b0;
        RdValid     = 1'b0;
        MisalignErr = 1'b0;
        TimeoutErr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (request) begin
                    Stall     = 1'b1;
                    state_nxt = (aligned && f3_ok) ? REQ : ERR;
                end
            end
            REQ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack)      state_nxt = DONE;
                else if (tmo_hit) state_nxt = ERR;
            end
            DONE: begin
                RdValid   = ~we_q;
                state_nxt = IDLE;
            end
            ERR: begin
                MisalignErr = ~tmo_q;
                TimeoutErr  = tmo_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            lane_q    <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            tmo_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            ReadData  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        lane_q    <= ALUResult[1:0];
                        f3_q      <= Funct3;
                        we_q      <= MemWrite;
                        tmo_q     <= 1'b0;
                        tmo_cnt   <= '0;
                        mem_we    <= MemWrite;
                        mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata <= wdata_nxt;
                        mem_be    <= be_nxt;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!we_q) ReadData <= ld_ext;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
